// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: evaluates the condition, computes the target,
// issues a held redirect to fetch (valid/ready) plus flush, and keeps statistics.
//
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   in_valid / in_ready              - branch + operands handshake
//   pc, rs1_data, rs2_data           - branch address and register operands
//   imm, branch_control              - signed B-type offset and decoded branch code
//   redirect_valid/ready, redirect_pc- taken-branch redirect to fetch
//   flush                            - squash younger instructions (redirect handshake)
//   misalign_err                     - taken target not word aligned (one-cycle pulse)
//   resolved_valid, resolved_taken   - one-cycle completion pulse and its outcome
//   branch_count, taken_count        - wrapping statistics counters

`ifndef BEQ
`define BEQ    3'b000
`endif
`ifndef BNE
`define BNE    3'b001
`endif
`ifndef BR_NOP
`define BR_NOP 3'b010
`endif
`ifndef BLT
`define BLT    3'b100
`endif
`ifndef BGE
`define BGE    3'b101
`endif
`ifndef BLTU
`define BLTU   3'b110
`endif
`ifndef BGEU
`define BGEU   3'b111
`endif

module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [12:0]      imm,
  input  logic [2:0]       branch_control,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             misalign_err,
  output logic             resolved_valid,
  output logic             resolved_taken,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    REDIRECT
  } state_t;

  state_t state;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [12:0]     imm_q;
  logic [2:0]      bc_q;

  logic            eq;
  logic            lt_s;
  logic            lt_u;
  logic            taken;
  logic [XLEN-1:0] imm_sx;
  logic [XLEN-1:0] target;
  logic            target_mis;

  assign in_ready = (state == IDLE);

  // Reset wins over a pending handshake, so no flush in a reset cycle.
  assign flush = redirect_valid && redirect_ready && !reset;

  assign eq   = (a_q == b_q);
  assign lt_s = ($signed(a_q) < $signed(b_q));
  assign lt_u = (a_q < b_q);

  always_comb begin
    taken = 1'b0;
    case (bc_q)
      `BEQ:    taken = eq;
      `BNE:    taken = !eq;
      `BLT:    taken = lt_s;
      `BGE:    taken = !lt_s;
      `BLTU:   taken = lt_u;
      `BGEU:   taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

  // Target wraps modulo 2^XLEN by construction.
  assign imm_sx     = {{(XLEN-13){imm_q[12]}}, imm_q};
  assign target     = pc_q + imm_sx;
  assign target_mis = (target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      pc_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      imm_q          <= '0;
      bc_q           <= `BR_NOP;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      misalign_err   <= 1'b0;
      resolved_valid <= 1'b0;
      resolved_taken <= 1'b0;
      branch_count   <= '0;
      taken_count    <= '0;
    end else begin
      resolved_valid <= 1'b0;
      resolved_taken <= 1'b0;
      misalign_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            pc_q  <= pc;
            a_q   <= rs1_data;
            b_q   <= rs2_data;
            imm_q <= imm;
            bc_q  <= branch_control;
            state <= EVAL;
          end
        end
        EVAL: begin
          resolved_valid <= 1'b1;
          resolved_taken <= taken;
          branch_count   <= branch_count + CNT_W'(1);
          if (taken) begin
            taken_count <= taken_count + CNT_W'(1);
          end
          if (taken && target_mis) begin
            misalign_err <= 1'b1;
            state        <= IDLE;
          end else if (taken) begin
            redirect_pc    <= target;
            redirect_valid <= 1'b1;
            state          <= REDIRECT;
          end else begin
            state <= IDLE;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases plus random
// branches checked against a behavioural model; counters run at CNT_W=4.

`ifndef BEQ
`define BEQ    3'b000
`endif
`ifndef BNE
`define BNE    3'b001
`endif
`ifndef BR_NOP
`define BR_NOP 3'b010
`endif
`ifndef BLT
`define BLT    3'b100
`endif
`ifndef BGE
`define BGE    3'b101
`endif
`ifndef BLTU
`define BLTU   3'b110
`endif
`ifndef BGEU
`define BGEU   3'b111
`endif

module tb_branch_resolve_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   pc;
  logic [31:0]   rs1_data;
  logic [31:0]   rs2_data;
  logic [12:0]   imm;
  logic [2:0]    branch_control;
  logic          redirect_valid;
  logic          redirect_ready;
  logic [31:0]   redirect_pc;
  logic          flush;
  logic          misalign_err;
  logic          resolved_valid;
  logic          resolved_taken;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] taken_count;

  int total = 0;
  int bad = 0;
  logic [CW-1:0] exp_bc = '0;
  logic [CW-1:0] exp_tc = '0;

  branch_resolve_unit #(.XLEN(32), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .pc             (pc),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .imm            (imm),
    .branch_control (branch_control),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .misalign_err   (misalign_err),
    .resolved_valid (resolved_valid),
    .resolved_taken (resolved_taken),
    .branch_count   (branch_count),
    .taken_count    (taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_taken(logic [2:0] bc, logic [31:0] a,
                                     logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (bc)
      `BEQ:    return a == b;
      `BNE:    return a != b;
      `BLT:    return sa < sb;
      `BGE:    return sa >= sb;
      `BLTU:   return a < b;
      `BGEU:   return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(logic [31:0] p, logic [12:0] im);
    int off;
    off = int'(im);
    if (im[12]) off = off - 8192;
    return p + 32'(off);
  endfunction

  task automatic run_br(input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] b, input logic [12:0] im,
                        input logic [2:0] bc, input int hold);
    logic tk;
    logic mis;
    logic [31:0] tgt;
    tk  = ref_taken(bc, a, b);
    tgt = ref_target(p, im);
    mis = tk && (tgt[1:0] != 2'b00);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1'b1);
    pc = p; rs1_data = a; rs2_data = b; imm = im; branch_control = bc;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'($urandom);
    pc = $urandom; rs1_data = $urandom; rs2_data = $urandom;
    imm = 13'($urandom); branch_control = 3'($urandom);
    chk("eval_busy", in_ready, 1'b0);
    chk("eval_no_resolve", resolved_valid, 1'b0);
    exp_bc = exp_bc + 1'b1;
    if (tk) exp_tc = exp_tc + 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("resolved_valid", resolved_valid, 1'b1);
    chk("resolved_taken", resolved_taken, tk);
    chk("misalign_err", misalign_err, mis);
    chk("redirect_valid", redirect_valid, tk && !mis);
    chk("branch_count", branch_count, exp_bc);
    chk("taken_count", taken_count, exp_tc);
    if (tk && !mis) begin
      chk("redirect_pc", redirect_pc, tgt);
      chk("redir_busy", in_ready, 1'b0);
      for (int i = 0; i < hold; i++) begin
        redirect_ready = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("hold_no_flush", flush, 1'b0);
        @(negedge clk);
        chk("hold_valid", redirect_valid, 1'b1);
        chk("hold_pc", redirect_pc, tgt);
        chk("hold_busy", in_ready, 1'b0);
        chk("hold_no_resolve", resolved_valid, 1'b0);
        chk("hold_no_mis", misalign_err, 1'b0);
      end
      in_valid = 1'b0;
      redirect_ready = 1'b1;
      #1;
      chk("flush", flush, 1'b1);
      @(negedge clk);
      chk("after_hs_valid", redirect_valid, 1'b0);
      chk("after_hs_flush", flush, 1'b0);
      chk("after_hs_ready", in_ready, 1'b1);
      chk("after_hs_no_resolve", resolved_valid, 1'b0);
      chk("after_hs_bc", branch_count, exp_bc);
      redirect_ready = 1'b0;
    end else begin
      redirect_ready = 1'($urandom);
      #1;
      chk("nt_no_flush", flush, 1'b0);
      chk("nt_ready", in_ready, 1'b1);
      @(negedge clk);
      chk("nt_mis_pulse", misalign_err, 1'b0);
      chk("nt_res_pulse", resolved_valid, 1'b0);
      chk("nt_no_redirect", redirect_valid, 1'b0);
      redirect_ready = 1'b0;
    end
  endtask

  initial begin
    logic [2:0] ops [7];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rp;
    logic [12:0] ri;
    ops = '{`BEQ, `BNE, `BLT, `BGE, `BLTU, `BGEU, 3'b011};
    reset = 1'b1;
    in_valid = 1'b0;
    pc = '0; rs1_data = '0; rs2_data = '0; imm = '0;
    branch_control = `BR_NOP;
    redirect_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_redirect_valid", redirect_valid, 1'b0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_misalign", misalign_err, 1'b0);
    chk("rst_resolved", resolved_valid, 1'b0);
    chk("rst_taken", resolved_taken, 1'b0);
    chk("rst_bc", branch_count, 4'h0);
    chk("rst_tc", taken_count, 4'h0);

    run_br(32'h100, 32'd5, 32'd5, 13'h010, `BEQ, 0);
    run_br(32'h100, 32'hFFFF_FFFF, 32'd1, 13'h020, `BLT, 1);
    run_br(32'h100, 32'hFFFF_FFFF, 32'd1, 13'h020, `BLTU, 0);
    run_br(32'h4, 32'd1, 32'd2, 13'h1FF8, `BNE, 0);
    run_br(32'h200, 32'd7, 32'd7, 13'h1000, `BEQ, 2);
    run_br(32'h100, 32'd9, 32'd9, 13'h002, `BGE, 0);
    run_br(32'h300, 32'd3, 32'd4, 13'h040, `BGEU, 0);
    run_br(32'h300, 32'd4, 32'd3, 13'h040, `BGEU, 5);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = ($urandom_range(2) == 0) ? ra : 32'($urandom);
      rp = $urandom;
      ri = 13'($urandom) & 13'h1FFE;
      if ($urandom_range(1) == 1) begin
        rp[1:0] = 2'b00;
        ri[1] = 1'b0;
      end
      run_br(rp, ra, rb, ri, ops[$urandom_range(6)], $urandom_range(3));
    end

    @(negedge clk);
    pc = 32'h100; rs1_data = 32'd1; rs2_data = 32'd1;
    imm = 13'h010; branch_control = `BEQ;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_redirect", redirect_valid, 1'b1);
    reset = 1'b1;
    redirect_ready = 1'b1;
    #1;
    chk("rst_cycle_no_flush", flush, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    exp_bc = '0;
    exp_tc = '0;
    chk("rst2_redirect_valid", redirect_valid, 1'b0);
    chk("rst2_flush", flush, 1'b0);
    chk("rst2_in_ready", in_ready, 1'b1);
    chk("rst2_redirect_pc", redirect_pc, 32'h0);
    chk("rst2_bc", branch_count, 4'h0);
    chk("rst2_tc", taken_count, 4'h0);
    redirect_ready = 1'b0;

    for (int n = 0; n < 16; n++) begin
      run_br(32'($urandom), 32'($urandom), 32'($urandom), 13'h010,
             `BR_NOP, 0);
    end
    chk("wrap_bc", branch_count, 4'h0);
    chk("wrap_tc", taken_count, 4'h0);

    if (bad != 0) begin
      $error("FAIL summary: %0d of %0d checks failed", bad, total);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
